fixed_to_fp_arbiter: RTL and testbench

- Shares a single fixed-point to IEEE-754 single-precision conversion datapath between NUM_REQ requesters.
- Each requester presents sign-magnitude samples in [-1, 1] over a valid/ready handshake. Format: 1 sign bit, 1 integer bit, 19 fraction bits.
- The block arbitrates round-robin, pipelines the conversion over two register stages, and returns the float tagged with the requester index on a valid/ready output port.
- Sits between the fixed-point compute units and the float-consuming stage.

---
 rtl/fixed_to_fp_arbiter_if.sv | 59 +++++
 rtl/fixed_to_fp_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fixed_to_fp_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_fp_arbiter_if.sv
// ---------------------------------------------------------------------------
// fixed_to_fp_arbiter_if
//
// Purpose: bundles the requester-side and result-side handshake signals of
// the fixed-point to float conversion arbiter into one interface.
//
// Signals:
//   req_valid  [NUM_REQ]      per-requester sample valid
//   req_data   [NUM_REQ*21]   packed samples, requester r at [21r+20:21r]
//                             = {sign, integer, fraction[18:0]}
//   req_ready  [NUM_REQ]      per-requester accept (one-hot or zero)
//   out_valid                 converted result valid
//   out_ready                 downstream accept
//   out_fp     [32]           IEEE-754 single-precision result
//   out_id     [ID_W]         requester index that produced out_fp
//   done_count [CNT_W]        completed output handshakes, wrapping
//
// Modports:
//   master : the environment (requesters plus float consumer)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface fixed_to_fp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*21-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_fp;
  logic [ID_W-1:0]       out_id;
  logic [CNT_W-1:0]      done_count;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_fp,
    input  out_id,
    input  done_count
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_fp,
    output out_id,
    output done_count
  );

endinterface

// File: rtl/fixed_to_fp_arbiter.sv
// ---------------------------------------------------------------------------
// fixed_to_fp_arbiter
//
// Purpose: shares one fixed-point to IEEE-754 single-precision converter
// between NUM_REQ requesters. Requests are granted round-robin, the sample
// passes through a two-register pipeline (S1 holds the raw sample, S2 is
// the output register holding the converted float), and the result leaves
// tagged with the index of the requester that produced it.
//
// Input sample format (sign-magnitude, range [-1, 1]):
//   {sign, integer, fraction[18:0]}
//
// Ports:
//   clk_i  : clock, all logic on the rising edge
//   rst_i  : synchronous active-high reset; flushes the pipeline, clears the
//            round-robin pointer and the done counter, and forces all
//            req_ready bits low while asserted
//   bus    : fixed_to_fp_arbiter_if.slave (request side, result side and
//            the completed-conversion counter)
// ---------------------------------------------------------------------------
module fixed_to_fp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  fixed_to_fp_arbiter_if.slave bus
);

  localparam int DATA_W = 21;

  // Round-robin pointer: the requester index the next scan starts from.
  logic [ID_W-1:0]   ptr_q;

  // Stage 1: raw accepted sample and its requester tag.
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [ID_W-1:0]   s1_id_q;

  // Stage 2: the output register.
  logic              out_valid_q;
  logic [31:0]       out_fp_q;
  logic [ID_W-1:0]   out_id_q;

  logic [CNT_W-1:0]  done_count_q;

  // Pipeline advance conditions and arbitration results.
  logic              adv1;
  logic              adv2;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [DATA_W-1:0] grant_data;
  logic              take_req;
  logic [NUM_REQ-1:0] ready_vec;
  logic [31:0]       s1_fp;

  // Adds an offset below NUM_REQ to a pointer and wraps modulo NUM_REQ.
  // Both operands are already below NUM_REQ, so one conditional subtract
  // is enough and NUM_REQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  // Converts a sign-magnitude {s, i, f[18:0]} sample to a single-precision
  // float. The magnitude is either exactly 1.0 (integer bit set; fraction is
  // ignored), exactly zero (always +0.0), or f * 2^-19. In the last case the
  // leading one of f at position k sets the exponent to 127 + (k - 19), and
  // the bits below it become the mantissa, left-justified and truncated.
  function automatic logic [31:0] fixed_to_float(input logic [DATA_W-1:0] d);
    logic        s;
    logic        i;
    logic [18:0] f;
    logic [4:0]  k;
    logic [18:0] norm;
    logic [7:0]  e;
    s = d[20];
    i = d[19];
    f = d[18:0];
    k = '0;
    for (int j = 0; j < 19; j++) begin
      if (f[j]) begin
        k = 5'(j);
      end
    end
    // Shift the leading one up to bit 18 so bits [17:0] are the fraction.
    norm = f << (5'd18 - k);
    e    = 8'd108 + {3'b000, k};
    if (i) begin
      return {s, 8'd127, 23'd0};
    end else if (f == '0) begin
      return 32'd0;
    end else begin
      return {s, e, norm[17:0], 5'd0};
    end
  endfunction

  // The output register can take a new value whenever it is empty or its
  // current value is being consumed this cycle; S1 can take a new sample
  // whenever it is empty or is draining into S2.
  assign adv2 = !out_valid_q || bus.out_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Round-robin scan: starting at the pointer and wrapping past the last
  // requester, the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_add(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_add(ptr_q, k);
      end
    end
  end

  // Select the granted requester's sample out of the packed data bus.
  always_comb begin
    grant_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_id == ID_W'(r)) begin
        grant_data = bus.req_data[r*DATA_W +: DATA_W];
      end
    end
  end

  // A grant is only offered when S1 has room, and never during reset, so a
  // raised ready bit always means the sample is taken on the coming edge.
  assign take_req = !rst_i && adv1 && grant_found;

  always_comb begin
    ready_vec = '0;
    if (take_req) begin
      ready_vec[grant_id] = 1'b1;
    end
  end

  assign s1_fp = fixed_to_float(s1_data_q);

  // Pointer, stage registers and counter. Reset drops anything in flight.
  // S2 only reloads its data when S1 actually holds a sample, so the last
  // result stays visible (with out_valid low) once the pipeline drains.
  // S1 is refilled by a new acceptance, otherwise it empties whenever it
  // hands its sample to S2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_id_q      <= '0;
      out_valid_q  <= 1'b0;
      out_fp_q     <= '0;
      out_id_q     <= '0;
      done_count_q <= '0;
    end else begin
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_fp_q <= s1_fp;
          out_id_q <= s1_id_q;
        end
      end

      if (take_req) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= grant_data;
        s1_id_q    <= grant_id;
        ptr_q      <= wrap_add(grant_id, 1);
      end else if (adv2) begin
        s1_valid_q <= 1'b0;
      end

      if (out_valid_q && bus.out_ready) begin
        done_count_q <= done_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_fp     = out_fp_q;
  assign bus.out_id     = out_id_q;
  assign bus.done_count = done_count_q;

  // At most one requester is ever granted.
  ready_onehot: assert property (@(posedge clk_i) $onehot0(ready_vec));

  // A result that is not taken must stay put until it is.
  hold_when_stalled: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_fp_q) && $stable(out_id_q))
  );

endmodule

// File: tb/tb_fixed_to_fp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fixed_to_fp_arbiter
//
// Purpose: directed, self-checking bench for fixed_to_fp_arbiter. A main
// instance uses the default 16-bit counter; a second instance with a 4-bit
// counter shares the same stimulus so counter wrap can be seen quickly.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 time unit later, well away from either clock edge.
// ---------------------------------------------------------------------------
module tb_fixed_to_fp_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct {
    int          req;
    logic [20:0] data;
    logic [31:0] fp;
  } conv_vec_t;

  typedef struct {
    logic [3:0]  valid;
    int          a_idx;
    int          b_idx;
    logic        oready;
    logic [3:0]  ready;
    logic        ov;
    logic [1:0]  id;
    logic [31:0] fp;
  } stall_vec_t;

  logic clk_i = 1'b0;
  logic rst_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fixed_to_fp_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(16)) bus ();
  fixed_to_fp_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(4))  bus4 ();

  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_data  = bus.req_data;
  assign bus4.out_ready = bus.out_ready;

  fixed_to_fp_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  fixed_to_fp_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(4)) dut4 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus4)
  );

  // One comparison: counts it, reports it on a miss.
  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [20:0] d);
    bus.req_data[r*21 +: 21] = d;
  endtask

  // Move to the drive point of the next cycle.
  task automatic apply_stimulus();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [20:0] smp(input logic s, input logic i,
                                      input logic [18:0] f);
    return {s, i, f};
  endfunction

  function automatic stall_vec_t mk_stall(input logic [3:0] valid,
      input int a_idx, input int b_idx, input logic oready,
      input logic [3:0] ready, input logic ov, input logic [1:0] id,
      input logic [31:0] fp);
    stall_vec_t v;
    v.valid = valid; v.a_idx = a_idx; v.b_idx = b_idx; v.oready = oready;
    v.ready = ready; v.ov = ov; v.id = id; v.fp = fp;
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    conv_vec_t   conv_tab[10];
    stall_vec_t  stall_tab[13];
    logic [31:0] stream_fp[4];
    logic [31:0] a_fp[3];
    logic [31:0] b_fp[2];
    logic [18:0] a_base;
    logic [18:0] b_base;
    logic [18:0] s_base;
    int          exp_done;

    conv_tab[0] = '{0, smp(1'b0, 1'b0, 19'h40000), 32'h3F000000};
    conv_tab[1] = '{1, smp(1'b1, 1'b1, 19'h12345), 32'hBF800000};
    conv_tab[2] = '{2, smp(1'b1, 1'b0, 19'h00000), 32'h00000000};
    conv_tab[3] = '{3, smp(1'b0, 1'b0, 19'h00001), 32'h36000000};
    conv_tab[4] = '{0, smp(1'b0, 1'b0, 19'h7FFFF), 32'h3F7FFFE0};
    conv_tab[5] = '{1, smp(1'b0, 1'b1, 19'h00000), 32'h3F800000};
    conv_tab[6] = '{2, smp(1'b1, 1'b0, 19'h40000), 32'hBF000000};
    conv_tab[7] = '{0, smp(1'b0, 1'b0, 19'h60000), 32'h3F400000};
    conv_tab[8] = '{1, smp(1'b1, 1'b0, 19'h00003), 32'hB6C00000};
    conv_tab[9] = '{3, smp(1'b0, 1'b0, 19'h12345), 32'h3E11A280};

    stream_fp[0] = 32'h3F000000;
    stream_fp[1] = 32'h3E800000;
    stream_fp[2] = 32'h3E000000;
    stream_fp[3] = 32'h3D800000;

    a_fp[0] = 32'h3F000000;
    a_fp[1] = 32'h3E800000;
    a_fp[2] = 32'h3E000000;
    b_fp[0] = 32'hBF400000;
    b_fp[1] = 32'hBEC00000;

    // r0 streams A0.., r2 streams B0..; downstream stalls in cycles 3..7.
    stall_tab[0]  = mk_stall(4'b0101, 0, 0, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0);
    stall_tab[1]  = mk_stall(4'b0101, 1, 0, 1'b1, 4'b0100, 1'b0, 2'd0, 32'h0);
    stall_tab[2]  = mk_stall(4'b0101, 1, 1, 1'b1, 4'b0001, 1'b1, 2'd0, a_fp[0]);
    for (int c = 3; c <= 7; c++) begin
      stall_tab[c] = mk_stall(4'b0101, 2, 1, 1'b0, 4'b0000, 1'b1, 2'd2, b_fp[0]);
    end
    stall_tab[8]  = mk_stall(4'b0101, 2, 1, 1'b1, 4'b0100, 1'b1, 2'd2, b_fp[0]);
    stall_tab[9]  = mk_stall(4'b0101, 2, 2, 1'b1, 4'b0001, 1'b1, 2'd0, a_fp[1]);
    stall_tab[10] = mk_stall(4'b0000, 2, 2, 1'b1, 4'b0000, 1'b1, 2'd2, b_fp[1]);
    stall_tab[11] = mk_stall(4'b0000, 2, 2, 1'b1, 4'b0000, 1'b1, 2'd0, a_fp[2]);
    stall_tab[12] = mk_stall(4'b0000, 2, 2, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);

    // Reset: ready must stay low even with every requester valid.
    rst_i         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    apply_stimulus();
    bus.req_valid = 4'hF;
    #1;
    check_output("ready_in_reset", 32'(bus.req_ready), 32'h0);
    apply_stimulus();
    rst_i         = 1'b0;
    bus.req_valid = '0;
    #1;
    check_output("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("reset_out_fp", bus.out_fp, 32'h0);
    check_output("reset_out_id", 32'(bus.out_id), 32'h0);
    check_output("reset_done", 32'(bus.done_count), 32'h0);
    check_output("reset_done4", 32'(bus4.done_count), 32'h0);

    // Single conversions, one requester at a time.
    exp_done = 0;
    for (int v = 0; v < 10; v++) begin
      apply_stimulus();
      set_req(conv_tab[v].req, conv_tab[v].data);
      bus.req_valid = 4'(1 << conv_tab[v].req);
      #1;
      check_output("conv_ready", 32'(bus.req_ready), 32'(1 << conv_tab[v].req));
      apply_stimulus();
      bus.req_valid = '0;
      #1;
      check_output("conv_latency", 32'(bus.out_valid), 32'h0);
      apply_stimulus();
      #1;
      check_output("conv_valid", 32'(bus.out_valid), 32'h1);
      check_output("conv_fp", bus.out_fp, conv_tab[v].fp);
      check_output("conv_id", 32'(bus.out_id), 32'(conv_tab[v].req));
      apply_stimulus();
      #1;
      exp_done++;
      check_output("conv_drained", 32'(bus.out_valid), 32'h0);
      check_output("conv_done", 32'(bus.done_count), 32'(exp_done));
    end

    // All four requesters valid: grants rotate 0,1,2,3 and results follow
    // two cycles later without gaps.
    for (int r = 0; r < NUM_REQ; r++) begin
      s_base = 19'h40000;
      set_req(r, smp(1'b0, 1'b0, s_base >> r));
    end
    for (int k = 0; k <= 10; k++) begin
      apply_stimulus();
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      check_output("rr_ready", 32'(bus.req_ready),
                   (k < 8) ? 32'(1 << (k % 4)) : 32'h0);
      if (k >= 2 && k < 10) begin
        check_output("rr_valid", 32'(bus.out_valid), 32'h1);
        check_output("rr_id", 32'(bus.out_id), 32'((k - 2) % 4));
        check_output("rr_fp", bus.out_fp, stream_fp[(k - 2) % 4]);
      end else begin
        check_output("rr_idle", 32'(bus.out_valid), 32'h0);
      end
    end
    exp_done += 8;
    check_output("rr_done", 32'(bus.done_count), 32'(exp_done));

    // r0/r2 streaming through a five-cycle downstream stall.
    a_base = 19'h40000;
    b_base = 19'h60000;
    for (int c = 0; c < 13; c++) begin
      apply_stimulus();
      set_req(0, smp(1'b0, 1'b0, a_base >> stall_tab[c].a_idx));
      set_req(2, smp(1'b1, 1'b0, b_base >> stall_tab[c].b_idx));
      bus.req_valid = stall_tab[c].valid;
      bus.out_ready = stall_tab[c].oready;
      #1;
      check_output("stall_ready", 32'(bus.req_ready), 32'(stall_tab[c].ready));
      check_output("stall_valid", 32'(bus.out_valid), 32'(stall_tab[c].ov));
      if (stall_tab[c].ov) begin
        check_output("stall_id", 32'(bus.out_id), 32'(stall_tab[c].id));
        check_output("stall_fp", bus.out_fp, stall_tab[c].fp);
      end
    end
    exp_done += 5;
    check_output("stall_done", 32'(bus.done_count), 32'(exp_done));

    // Reset with two samples in flight; pointer is 3 just before reset.
    apply_stimulus();
    set_req(1, smp(1'b0, 1'b0, 19'h40000));
    bus.req_valid = 4'b0010;
    bus.out_ready = 1'b0;
    #1;
    check_output("flight_ready_r1", 32'(bus.req_ready), 32'h2);
    apply_stimulus();
    set_req(2, smp(1'b0, 1'b0, 19'h20000));
    bus.req_valid = 4'b0100;
    #1;
    check_output("flight_ready_r2", 32'(bus.req_ready), 32'h4);
    apply_stimulus();
    rst_i         = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    check_output("flight_out_valid", 32'(bus.out_valid), 32'h1);
    check_output("flight_ready_rst", 32'(bus.req_ready), 32'h0);
    apply_stimulus();
    rst_i = 1'b0;
    set_req(1, smp(1'b0, 1'b0, 19'h10000));
    set_req(3, smp(1'b0, 1'b0, 19'h08000));
    bus.out_ready = 1'b1;
    #1;
    check_output("flush_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("flush_done", 32'(bus.done_count), 32'h0);
    check_output("flush_out_fp", bus.out_fp, 32'h0);
    check_output("flush_out_id", 32'(bus.out_id), 32'h0);
    check_output("flush_first_grant", 32'(bus.req_ready), 32'h2);
    apply_stimulus();
    bus.req_valid = '0;
    #1;
    check_output("flush_no_ghost", 32'(bus.out_valid), 32'h0);
    apply_stimulus();
    #1;
    check_output("flush_new_valid", 32'(bus.out_valid), 32'h1);
    check_output("flush_new_id", 32'(bus.out_id), 32'h1);
    check_output("flush_new_fp", bus.out_fp, 32'h3E000000);
    apply_stimulus();
    #1;
    check_output("flush_new_drained", 32'(bus.out_valid), 32'h0);
    check_output("flush_new_done", 32'(bus.done_count), 32'h1);

    // Counter wrap on the 4-bit instance: 17 back-to-back conversions.
    apply_stimulus();
    rst_i = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      s_base = 19'h40000;
      set_req(r, smp(1'b0, 1'b0, s_base >> r));
    end
    for (int k = 0; k < 20; k++) begin
      apply_stimulus();
      rst_i         = 1'b0;
      bus.req_valid = (k < 17) ? 4'hF : 4'h0;
      #1;
      if (k == 0) begin
        check_output("wrap_start", 32'(bus4.done_count), 32'h0);
      end else if (k == 17) begin
        check_output("wrap_15", 32'(bus4.done_count), 32'd15);
      end else if (k == 18) begin
        check_output("wrap_0", 32'(bus4.done_count), 32'd0);
        check_output("wrap_main_16", 32'(bus.done_count), 32'd16);
      end else if (k == 19) begin
        check_output("wrap_1", 32'(bus4.done_count), 32'd1);
        check_output("wrap_main_17", 32'(bus.done_count), 32'd17);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
